// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the regfile write port among writeback sources.
// Ports: clk/rst (sync, active-high), hold, req_valid/req_ready/req_addr/req_data
// per source (packed), rf_we/rf_waddr/rf_wdata registered to the regfile, busy.
// Optional macro WB_CONFLICT_CNT_EN adds conflict_cnt (saturating, 16 bits).
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        hold,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic                        rf_we,
  output logic [ADDR_W-1:0]           rf_waddr,
  output logic [DATA_W-1:0]           rf_wdata,
  output logic                        busy
`ifdef WB_CONFLICT_CNT_EN
  ,
  output logic [15:0]                 conflict_cnt
`endif
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  waddr_q, waddr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;

  logic [NUM_REQ-1:0] gnt;
  logic               found;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;
  logic [PTR_W-1:0]   nxt_ptr;
  int                 idx;

  // Search ptr, ptr+1, ... with wrap; the inner loop keeps every
  // select index constant.
  always_comb begin
    gnt      = '0;
    found    = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    nxt_ptr  = ptr_q;
    idx      = 0;
    if (!rst && !hold) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = int'(ptr_q) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (!found && idx == i && req_valid[i]) begin
            found    = 1'b1;
            gnt[i]   = 1'b1;
            sel_addr = req_addr[i*ADDR_W +: ADDR_W];
            sel_data = req_data[i*DATA_W +: DATA_W];
            nxt_ptr  = (i == NUM_REQ-1) ? '0 : PTR_W'(i + 1);
          end
        end
      end
    end
  end

  assign req_ready = gnt;

  always_comb begin
    ptr_d   = ptr_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (found) begin
      ptr_d   = nxt_ptr;
      // x0 writes are consumed but never reach the port.
      we_d    = (sel_addr != '0);
      waddr_d = sel_addr;
      wdata_d = sel_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign rf_we    = we_q;
  assign rf_waddr = waddr_q;
  assign rf_wdata = wdata_q;
  assign busy     = we_q;

`ifdef WB_CONFLICT_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!hold && $countones(req_valid) >= 2 && cnt_q != 16'hFFFF)
      cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign conflict_cnt = cnt_q;
`endif

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between NUM_REQ writeback sources, e.g. ALU pipe, load unit and multi-cycle mul/div.
- Round-robin arbitration with a per-source valid/ready handshake.
- Registered output stage drives the regfile's we/waddr/wdata directly.
- Sits between the execute/memory units and the regfile in the CPU top.

Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8).
- ADDR_W, 5, register address width (matches RegNumLog2).
- DATA_W, 32, register data width (matches RegBus).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- hold  in  1  pipeline stall; no grants issued while high
- req_valid  in  NUM_REQ  request i presents a write
- req_ready  out  NUM_REQ  one-hot grant; handshake completes when valid&ready
- req_addr  in  NUM_REQ*ADDR_W  packed; slice i = [i*ADDR_W +: ADDR_W]
- req_data  in  NUM_REQ*DATA_W  packed; slice i = [i*DATA_W +: DATA_W]
- rf_we  out  1  to regfile we
- rf_waddr  out  ADDR_W  to regfile waddr
- rf_wdata  out  DATA_W  to regfile wdata
- busy  out  1  rf_we asserted this cycle, registered

Behaviour:
- Reset (rst=1 at posedge):
  - rf_we=0, rf_waddr=0, rf_wdata=0, busy=0, rr pointer ptr=0.
  - req_ready is combinationally 0 while rst=1.
  - A grant in flight during reset is discarded; nothing is written in the cycle after reset.
- Grant logic, combinational:
  - If hold=0 and rst=0, req_ready has exactly one bit set: the first i with req_valid[i]=1, searching ptr, ptr+1, ..., NUM_REQ-1, 0, ..., ptr-1.
  - If no request is valid, req_ready=0.
  - req_ready never asserts for an invalid requester.
- Pointer update:
  - On a grant to i, ptr <= (i+1) mod NUM_REQ, with wrap from NUM_REQ-1 to 0.
  - With no grant, ptr is unchanged.
- Output stage, 1-cycle latency:
  - On a grant to i at edge N: rf_we=1, rf_waddr=req_addr[i], rf_wdata=req_data[i] during cycle N+1.
  - With no grant: rf_we=0, and rf_waddr/rf_wdata hold their last values.
- Register 0 writes:
  - A granted request with req_addr[i]=0 is consumed normally (ready=1, ptr advances).
  - The registered rf_we is 0 for it; x0 writes never reach the port.
- busy mirrors rf_we.
- Requester obligations:
  - Once valid is raised it stays high, with addr/data stable, until ready.
  - The arbiter does not latch unaccepted requests.
- hold=1 suppresses all grants; ptr is frozen; rf_we=0 in the following cycle. An already-registered write still completes in its cycle.
- Same-address requests from two sources in one cycle are serialized in arbitration order; the later grant's data is the final register value.
- Throughput: one write per cycle. No source waits more than NUM_REQ-1 grants once valid (fairness bound).

Optional Feature:
- Macro WB_CONFLICT_CNT_EN.
- Defined:
  - Adds output conflict_cnt, 16 bits.
  - Increments, saturating at 16'hFFFF, on every cycle with hold=0 and popcount(req_valid)>=2.
  - Reset to 0 by rst.
- Undefined: port and counter absent; no other behaviour changes.

Test Plan:
- Reset release, req_valid=3'b000 for 5 cycles -> req_ready=0, rf_we=0 throughout, ptr=0.
- req_valid=3'b111 held 6 cycles, addrs 1/2/3, data 'hA/'hB/'hC -> grants 0,1,2,0,1,2; rf_waddr sequence 1,2,3,1,2,3 each one cycle after its grant.
- Only req 2 valid, addr 0, data 'hDEAD -> req_ready=3'b100, ptr becomes 0, next cycle rf_we=0.
- req_valid=3'b011 with hold=1 for 3 cycles, then hold=0 -> no ready and rf_we=0 during hold; first grant after hold goes to req 0 (ptr=0).
- Reset asserted the cycle after a grant to req 1 (addr 7) -> rf_we=0 after reset edge, ptr=0.
- With WB_CONFLICT_CNT_EN, req_valid=3'b101 for 4 cycles then 3'b001 for 2 cycles -> conflict_cnt=4.
